ps2_host_tx: RTL

//  PS/2 host-to-device transmitter; the send side of the keyboard/mouse link whose device-to-host bytes ps2k decodes.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_host_tx_sync.sv | 68 ++++++
 rtl/ps2_host_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, frame
// bit positions and cycle-count helpers derived from the system clock rate.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INHIBIT  = 3'd1,
      ST_START    = 3'd2,
      ST_FRAME    = 3'd3,
      ST_WAITIDLE = 3'd4
   } ps2_state_t;

   // Falling-edge numbers within a frame (edge 1..8 = data bits 0..7)
   localparam logic [3:0] BIT_PARITY = 4'd9;
   localparam logic [3:0] BIT_STOP   = 4'd10;
   localparam logic [3:0] BIT_ACK    = 4'd11;

   // Clock-low inhibit time before the start bit, in system clock cycles
   function automatic int inhibit_cycles(input int clk_khz, input int inhibit_us);
      return clk_khz * inhibit_us / 1000;
   endfunction

   // Limit from clock release to ACK, in system clock cycles
   function automatic int timeout_cycles(input int clk_khz, input int timeout_ms);
      return clk_khz * timeout_ms;
   endfunction

   // Payload plus odd parity, shifted out LSB first
   function automatic logic [8:0] frame_bits(input logic [7:0] d);
      return {~^d, d};
   endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Pin conditioner for one PS/2 line: two-flop synchroniser, optional level
// filter (PS2_FILTER_EN) and a one-cycle falling-edge pulse.
module ps2_host_tx_sync #(
   parameter int FILTER = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic pin,
   output logic lvl,
   output logic fall
);

   logic s1;
   logic s2;

   // Synchronise the asynchronous pin; idle PS/2 lines are high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= pin;
         s2 <= s1;
      end
   end

`ifdef PS2_FILTER_EN
   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

   logic [CW-1:0] cnt;

   // Adopt a new level only after FILTER consecutive samples agree on it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lvl  <= 1'b1;
         cnt  <= '0;
         fall <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            lvl  <= s2;
            cnt  <= '0;
            fall <= ~s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
`else
   logic prv;
   logic unused_filter;

   assign unused_filter = ^FILTER;

   // Previous synchronised level for edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prv <= 1'b1;
      else        prv <= s2;
   end

   assign lvl  = s2;
   assign fall = prv & ~s2;
`endif

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a start bit,
// shifts a byte plus odd parity out on device clock falls, then checks the
// device ACK. Optional input filtering with PS2_FILTER_EN.
// Handshake: strb is a one-cycle request honoured only while busy=0; the byte
// on data is captured in that cycle; busy stays high until the single-cycle
// done (ACK) or error (NACK/timeout) pulse, and drops in the same cycle.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLK_KHZ    = 56000,
   parameter int INHIBIT_US = 120,
   parameter int TIMEOUT_MS = 15,
   parameter int FILTER     = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       strb,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2ckI,
   input  logic       ps2dqI,
   output logic       ps2ckO,
   output logic       ps2dqO,
   output logic [2:0] state_dbg
);

   localparam int INH_CYC = inhibit_cycles(CLK_KHZ, INHIBIT_US);
   localparam int TO_CYC  = timeout_cycles(CLK_KHZ, TIMEOUT_MS);
   localparam int INH_W   = $clog2(INH_CYC);
   localparam int TO_W    = $clog2(TO_CYC);
   // The START cycle also keeps the clock low, so INHIBIT ends one cycle early
   // to make the total clock-low time exactly INH_CYC cycles.
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

   ps2_state_t       state;
   logic [8:0]       sh;
   logic [3:0]       n;
   logic [3:0]       n_nxt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             ck_lvl;
   logic             ck_fall;
   logic             dq_lvl;
   logic             dq_fall_unused;

   ps2_host_tx_sync #(.FILTER(FILTER)) u_ck_sync (
      .clock (clock),
      .reset (reset),
      .pin   (ps2ckI),
      .lvl   (ck_lvl),
      .fall  (ck_fall)
   );

   ps2_host_tx_sync #(.FILTER(FILTER)) u_dq_sync (
      .clock (clock),
      .reset (reset),
      .pin   (ps2dqI),
      .lvl   (dq_lvl),
      .fall  (dq_fall_unused)
   );

   assign n_nxt     = n + 4'd1;
   assign state_dbg = state;

   // Transmit sequencer with registered line drivers and status pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         ps2ckO  <= 1'b0;
         ps2dqO  <= 1'b0;
         sh      <= '0;
         n       <= '0;
         inh_cnt <= '0;
         to_cnt  <= '0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (strb) begin
                  sh      <= frame_bits(data);
                  n       <= '0;
                  busy    <= 1'b1;
                  ps2ckO  <= 1'b1;
                  inh_cnt <= '0;
                  state   <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (inh_cnt == INH_LAST) begin
                  ps2dqO <= 1'b1;
                  state  <= ST_START;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            ST_START: begin
               ps2ckO <= 1'b0;
               to_cnt <= '0;
               state  <= ST_FRAME;
            end
            ST_FRAME, ST_WAITIDLE: begin
               if (to_cnt == TO_LAST) begin
                  ps2ckO <= 1'b0;
                  ps2dqO <= 1'b0;
                  error  <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
                  if (state == ST_FRAME) begin
                     if (ck_fall) begin
                        n <= n_nxt;
                        case (n_nxt)
                           BIT_STOP: ps2dqO <= 1'b0;
                           BIT_ACK: begin
                              if (!dq_lvl) begin
                                 state <= ST_WAITIDLE;
                              end else begin
                                 error <= 1'b1;
                                 busy  <= 1'b0;
                                 state <= ST_IDLE;
                              end
                           end
                           default: ps2dqO <= ~sh[n_nxt - 4'd1];
                        endcase
                     end
                  end else if (ck_lvl && dq_lvl) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
